ahb_lite_sram_slave: RTL and testbench

//  AHB-Lite slave wrapping a single-port word-organised SRAM model (zero wait states).

---
 rtl/ahb_lite_sram_slave.sv | 145 ++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: zero-wait-state AHB-Lite slave in front of a word-organised SRAM.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   hsel, haddr, hburst, htrans,      AHB-Lite address phase (hburst/hprot accepted, unused)
//   hsize, hprot, hwrite, hready
//   hwdata                            write data, sampled in the data phase
//   hreadyout, hresp                  always ready / always OKAY
//   hrdata                            combinational read of the registered word address

module ahb_lite_sram_slave_mem #(
  parameter int unsigned mem_depth = 1024,
  parameter int unsigned mem_abit  = 10,
  parameter int unsigned mem_dw    = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic [3:0]          be,
  input  logic [mem_abit-1:0] addr,
  input  logic [mem_dw-1:0]   wdata,
  output logic [mem_dw-1:0]   rdata
);

  // Storage is deliberately not reset; contents survive rstn.
  logic [mem_dw-1:0] mem [0:mem_depth-1];

  // Byte-lane write, little-endian lanes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Asynchronous read port.
  assign rdata = mem[addr];

endmodule

module ahb_lite_sram_slave #(
  parameter int unsigned mem_depth = 1024,
  parameter int unsigned mem_abit  = 10,
  parameter int unsigned mem_dw    = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                hsel,
  input  logic [mem_abit+1:0] haddr,
  input  logic [2:0]          hburst,
  input  logic [1:0]          htrans,
  input  logic [2:0]          hsize,
  input  logic [3:0]          hprot,
  input  logic                hwrite,
  input  logic [mem_dw-1:0]   hwdata,
  input  logic                hready,
  output logic                hreadyout,
  output logic [mem_dw-1:0]   hrdata,
  output logic [1:0]          hresp
);

  // Pending data-phase state captured from the accepted address phase.
  logic                valid_q, valid_d;
  logic                wr_q,    wr_d;
  logic [mem_abit-1:0] waddr_q, waddr_d;
  logic [1:0]          lo_q,    lo_d;
  logic [2:0]          size_q,  size_d;
  logic                hreadyout_q;
  logic [1:0]          hresp_q;

  logic                accept_c;
  logic [3:0]          be_c;
  logic                mem_we_c;

  // Burst type, protection and the SEQ/NONSEQ distinction carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, htrans[0]};

  // Only NONSEQ/SEQ with select and bus ready start a transfer.
  assign accept_c = hsel & hready & htrans[1];

  // Next-state for the data-phase register; a non-accepted cycle clears the pending phase.
  always_comb begin
    valid_d = accept_c;
    wr_d    = wr_q;
    waddr_d = waddr_q;
    lo_d    = lo_q;
    size_d  = size_q;
    if (accept_c) begin
      wr_d    = hwrite;
      waddr_d = haddr[mem_abit+1:2];
      lo_d    = haddr[1:0];
      size_d  = hsize;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= 1'b0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      lo_q        <= 2'b00;
      size_q      <= 3'b000;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
    end else begin
      valid_q     <= valid_d;
      wr_q        <= wr_d;
      waddr_q     <= waddr_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
    end
  end

  // Byte-lane enables; low address bits below the access size are ignored.
  always_comb begin
    be_c = 4'b1111;
    case (size_q)
      3'd0:    be_c = 4'(4'b0001 << lo_q);
      3'd1:    be_c = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  // Write commits at the edge ending its data phase; reset clears valid_q so nothing lands.
  assign mem_we_c = valid_q & wr_q;

  ahb_lite_sram_slave_mem #(
    .mem_depth (mem_depth),
    .mem_abit  (mem_abit),
    .mem_dw    (mem_dw)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .be    (be_c),
    .addr  (waddr_q),
    .wdata (hwdata),
    .rdata (hrdata)
  );

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: directed AHB-Lite sequences plus random traffic
// checked against an array-based memory model.
module tb_ahb_lite_sram_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [11:0] haddr;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference memory and which words hold a fully defined value.
  logic [31:0] ref_mem [0:1023];
  bit          known   [0:1023];

  // Previous accepted beat, now in its data phase.
  bit          prev_vld;
  bit          prev_wr;
  logic [11:0] prev_addr;
  logic [2:0]  prev_size;
  logic [31:0] prev_wdata;

  always #5 clk = ~clk;

  ahb_lite_sram_slave dut (
    .clk       (clk),
    .rstn      (rstn),
    .hsel      (hsel),
    .haddr     (haddr),
    .hburst    (hburst),
    .htrans    (htrans),
    .hsize     (hsize),
    .hprot     (hprot),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hrdata    (hrdata),
    .hresp     (hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of a committed write: lanes chosen from size and byte address.
  task automatic model_write(input logic [11:0] addr, input logic [2:0] size, input logic [31:0] data);
    int word;
    int first;
    int count;
    word = int'(addr) / 4;
    if (size == 3'd0) begin
      first = int'(addr) % 4; count = 1;
    end else if (size == 3'd1) begin
      first = (int'(addr) % 4 >= 2) ? 2 : 0; count = 2;
    end else begin
      first = 0; count = 4;
    end
    for (int l = first; l < first + count; l++) ref_mem[word][8*l +: 8] = data[8*l +: 8];
    if (count == 4) known[word] = 1'b1;
  endtask

  // One bus cycle: present an address phase and the data of the previous beat.
  task automatic cycle(input bit sel, input bit rdy, input logic [1:0] trans, input bit wr,
                       input logic [11:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    bit acc;
    hsel   = sel;
    hready = rdy;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hprot  = 4'($urandom);
    hwdata = (prev_vld && prev_wr) ? prev_wdata : $urandom;
    acc    = sel && rdy && trans[1];
    @(negedge clk);
    chk("hreadyout", 32'(hreadyout), 32'd1);
    chk("hresp", 32'(hresp), 32'd0);
    if (prev_vld && !prev_wr) chk($sformatf("hrdata@%03h", prev_addr), hrdata, ref_mem[int'(prev_addr) / 4]);
    @(posedge clk);
    #1;
    if (prev_vld && prev_wr) model_write(prev_addr, prev_size, prev_wdata);
    prev_vld   = acc;
    prev_wr    = wr;
    prev_addr  = addr;
    prev_size  = size;
    prev_wdata = wdata;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 12'h0, 3'd2, 32'h0);
  endtask

  task automatic wr_word(input logic [11:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, 2'b10, 1'b1, a, 3'd2, d);
  endtask

  task automatic rd_word(input logic [11:0] a);
    cycle(1'b1, 1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0);
  endtask

  initial begin
    int w;
    logic [11:0] a;
    logic [2:0]  s;
    logic [31:0] d;
    logic [1:0]  t;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 32'h0;
      known[i]   = 1'b0;
    end
    prev_vld = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_size = '0; prev_wdata = '0;
    rstn = 1'b0; hsel = 1'b0; haddr = '0; hburst = 3'd0; htrans = 2'b00; hsize = 3'd2;
    hprot = 4'd0; hwrite = 1'b0; hwdata = '0; hready = 1'b1;

    // Reset held 10 cycles, with bus activity that must not be accepted.
    for (int i = 0; i < 10; i++) begin
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 12'h010; hwdata = $urandom;
      @(negedge clk);
      chk("rst_hreadyout", 32'(hreadyout), 32'd1);
      chk("rst_hresp", 32'(hresp), 32'd0);
    end
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(); idle();

    // Word write then read.
    wr_word(12'h010, 32'h1234_5678);
    idle();
    rd_word(12'h010);
    idle();
    chk("ref_word", ref_mem[4], 32'h1234_5678);

    // Byte then halfword writes.
    cycle(1'b1, 1'b1, 2'b10, 1'b1, 12'h011, 3'd0, 32'h0000_AA00);
    rd_word(12'h010);
    idle();
    chk("ref_byte", ref_mem[4], 32'h1234_AA78);
    cycle(1'b1, 1'b1, 2'b10, 1'b1, 12'h012, 3'd1, 32'hBEEF_0000);
    rd_word(12'h010);
    idle();
    chk("ref_half", ref_mem[4], 32'hBEEF_AA78);

    // INCR4 burst write then INCR4 burst read, back-to-back beats.
    hburst = 3'b011;
    wr_word(12'h020, 32'h11);
    cycle(1'b1, 1'b1, 2'b11, 1'b1, 12'h024, 3'd2, 32'h22);
    cycle(1'b1, 1'b1, 2'b11, 1'b1, 12'h028, 3'd2, 32'h33);
    cycle(1'b1, 1'b1, 2'b11, 1'b1, 12'h02C, 3'd2, 32'h44);
    rd_word(12'h020);
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 12'h024, 3'd2, 32'h0);
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 12'h028, 3'd2, 32'h0);
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 12'h02C, 3'd2, 32'h0);
    idle();
    hburst = 3'b000;

    // Write immediately followed by read of the same word.
    wr_word(12'h040, 32'hCAFE_F00D);
    rd_word(12'h040);
    idle();

    // Non-accepted writes: IDLE, BUSY, hsel low, hready low.
    cycle(1'b1, 1'b1, 2'b00, 1'b1, 12'h010, 3'd2, 32'hDEAD_0001);
    cycle(1'b1, 1'b1, 2'b01, 1'b1, 12'h010, 3'd2, 32'hDEAD_0002);
    cycle(1'b0, 1'b1, 2'b10, 1'b1, 12'h010, 3'd2, 32'hDEAD_0003);
    cycle(1'b1, 1'b0, 2'b10, 1'b1, 12'h010, 3'd2, 32'hDEAD_0004);
    rd_word(12'h010);
    idle();
    chk("ref_noacc", ref_mem[4], 32'hBEEF_AA78);

    // Last word, plus unaligned word address whose low bits are ignored.
    wr_word(12'hFFC, 32'h0BAD_F00D);
    rd_word(12'hFFC);
    cycle(1'b1, 1'b1, 2'b10, 1'b1, 12'hFFE, 3'd2, 32'h7777_8888);
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 12'hFFD, 3'd0, 32'h0);
    idle();
    chk("ref_last", ref_mem[1023], 32'h7777_8888);

    // Reset asserted during a write data phase drops the write.
    wr_word(12'h030, 32'h5555_AAAA);
    idle();
    wr_word(12'h030, 32'h0F0F_0F0F);
    rstn = 1'b0;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0F0F_0F0F;
    @(negedge clk);
    chk("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    prev_vld = 1'b0;
    rd_word(12'h030);
    idle();
    chk("ref_rst_drop", ref_mem[12], 32'h5555_AAAA);

    // Random traffic over a 64-word window: seed it, then mix everything.
    for (int i = 0; i < 64; i++) wr_word(12'(12'h100 + 4 * i), $urandom);
    for (int i = 0; i < 400; i++) begin
      w = 64 + int'($urandom_range(0, 63));
      s = 3'($urandom_range(0, 3));
      a = 12'(w * 4 + int'($urandom_range(0, 3)));
      d = $urandom;
      t = 2'($urandom);
      hburst = 3'($urandom);
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), t, ($urandom_range(0, 1) == 1),
            a, s, d);
    end
    idle(); idle();
    for (int i = 0; i < 64; i++) rd_word(12'(12'h100 + 4 * i));
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
